voltage_scale_pipe: RTL
=======================

// Module: voltage_scale_pipe
// PURPOSE
//  Multi-channel, pipelined successor of the ADC-code-to-display scaler. Per sample:
//   out = (mean*BASE_GAIN + (DATA_IN-mean)*GAIN[scale]) >>> FRAC_W, saturated.
//  Zooms about each channel's mean and scales to display units (x10000/1024 at scale 0).
//  Sits between the per-channel RAM/mean path and the VGA renderer.
//  Tagged valid pipeline plus a per-channel last-result register bank.
// PARAMETERS
//  N_CH      2      number of channels (>=1); CH_W = max(1,$clog2(N_CH))
//  IN_W      12     ADC code width (unsigned)
//  OUT_W     25     output width (unsigned)
//  GAIN_W    16     unsigned gain-constant width
//  FRAC_W    10     right shift applied to accumulator (divide by 1024)
//  BASE_GAIN 10000  gain applied to mean term
//  G0..G4    10000,5000,2500,1000,100  per-scale gains; scale codes 5..7 use G4
// PORTS
//  CLK       in   1            system clock, all logic on rising edge
//  RST       in   1            asynchronous active-high reset
//  IN_VALID  in   1            sample strobe, one sample per cycle max
//  IN_CH     in   CH_W         channel of sample; values >= N_CH are dropped
//  DATA_IN   in   IN_W         ADC code
//  MEAN      in   N_CH*IN_W    per-channel mean, channel k at [k*IN_W +: IN_W]
//  SCALE     in   N_CH*3       per-channel scale code, channel k at [k*3 +: 3]
//  OUT_VALID out  1            result strobe
//  OUT_CH    out  CH_W         channel tag of result
//  DATA_OUT  out  OUT_W        scaled result
//  SAT       out  1            result was clamped (valid with OUT_VALID)
//  LAST_OUT  out  N_CH*OUT_W   most recent result per channel
// BEHAVIOUR
//  - Reset (async assert, sync-released by CLK domain): all pipeline valids, OUT_VALID,
//    OUT_CH, DATA_OUT, SAT, LAST_OUT = 0. Reset mid-flight discards in-flight samples.
//  - Pipeline, no backpressure, fixed latency 3: sample accepted at edge N appears with
//    OUT_VALID=1 after edge N+3. Back-to-back samples give back-to-back results.
//  - S1: if IN_VALID && IN_CH<N_CH, capture diff = DATA_IN - MEAN[ch] (signed IN_W+1),
//    mean, gain = GAIN[SCALE[ch]], ch. MEAN/SCALE sampled here only; later changes do
//    not affect an accepted sample. Invalid channel -> v1=0, no output ever.
//  - S2: prod = diff*gain (signed), base = mean*BASE_GAIN; both in ACC_W =
//    IN_W+GAIN_W+2 signed bits, no intermediate truncation.
//  - S3: acc = base + prod (+ rounding, see CONFIGURATION); r = acc >>> FRAC_W;
//    r<0 -> DATA_OUT=0,SAT=1; r>2^OUT_W-1 -> DATA_OUT=all-ones,SAT=1; else r,SAT=0.
//  - LAST_OUT[OUT_CH] updated on the same edge OUT_VALID asserts; other channels hold.
//  - When OUT_VALID=0, DATA_OUT/OUT_CH/SAT hold their last values.
//  - With defaults (all G <= BASE_GAIN) acc >= 0 and max 4095*10000>>10 = 39990;
//    saturation only reachable with overridden gains.
// CONFIGURATION
//  VSCALE_ROUND_EN defined: S3 adds 2^(FRAC_W-1) to acc before the shift
//    (round half up, applied before saturation).
//  VSCALE_ROUND_EN undefined: plain arithmetic shift (truncate toward -inf).
//  Latency and interface identical either way.
// TESTING
//  1 Reset: hold RST, drive IN_VALID=1 -> all outputs 0; release, no OUT_VALID for 3 cycles.
//  2 ch0, scale0, MEAN=0, DATA_IN=1024 -> 3 cycles later DATA_OUT=10000, OUT_CH=0, SAT=0,
//    LAST_OUT[ch0]=10000.
//  3 ch1, scale3, MEAN=2048, DATA_IN=3072 -> DATA_OUT=21000; LAST_OUT[ch0] unchanged.
//  4 Stream 8 back-to-back samples alternating ch0/ch1 with SCALE changed every cycle ->
//    8 consecutive OUT_VALIDs, each matching the scale sampled at S1; IN_CH=N_CH dropped.
//  5 G4=20000 override, scale4, MEAN=2048, DATA_IN=0 -> DATA_OUT=0, SAT=1; DATA_IN=4095
//    with BASE_GAIN=40000 -> DATA_OUT=2^25-1? only if exceeded, else check exact value.
//  6 scale0, MEAN=0, DATA_IN=1 -> 9 without VSCALE_ROUND_EN, 10 with it; assert RST
//    with 2 samples in flight -> neither emerges.

Source files
------------

// File: rtl/voltage_scale_pipe.sv
// Multi-channel pipelined ADC-code-to-display scaler: zooms each sample about its channel mean.
// Optional round-half-up before the final shift when VSCALE_ROUND_EN is defined.
module voltage_scale_pipe #(
  parameter int N_CH      = 2,
  parameter int IN_W      = 12,
  parameter int OUT_W     = 25,
  parameter int GAIN_W    = 16,
  parameter int FRAC_W    = 10,
  parameter int BASE_GAIN = 10000,
  parameter int G0        = 10000,
  parameter int G1        = 5000,
  parameter int G2        = 2500,
  parameter int G3        = 1000,
  parameter int G4        = 100,
  parameter int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  IN_VALID,
  input  logic [CH_W-1:0]       IN_CH,
  input  logic [IN_W-1:0]       DATA_IN,
  input  logic [N_CH*IN_W-1:0]  MEAN,
  input  logic [N_CH*3-1:0]     SCALE,
  output logic                  OUT_VALID,
  output logic [CH_W-1:0]       OUT_CH,
  output logic [OUT_W-1:0]      DATA_OUT,
  output logic                  SAT,
  output logic [N_CH*OUT_W-1:0] LAST_OUT
);

  localparam int ACC_W = IN_W + GAIN_W + 2;
  localparam logic signed [ACC_W-1:0] BASE_X  = ACC_W'(BASE_GAIN);
  localparam logic signed [63:0]      MAX_OUT = (64'sd1 <<< OUT_W) - 64'sd1;
`ifdef VSCALE_ROUND_EN
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) <<< (FRAC_W - 1);
`else
  localparam logic signed [ACC_W-1:0] RND = '0;
`endif

  // Reset asserts immediately but is released only on a clock edge.
  logic [1:0] rst_pipe_q;
  logic       rst_sync;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rst_pipe_q <= 2'b11;
    end else begin
      rst_pipe_q <= {rst_pipe_q[0], 1'b0};
    end
  end

  assign rst_sync = rst_pipe_q[1];

  function automatic logic [GAIN_W-1:0] gain_of(input logic [2:0] s);
    logic [GAIN_W-1:0] g;
    case (s)
      3'd0:    g = GAIN_W'(G0);
      3'd1:    g = GAIN_W'(G1);
      3'd2:    g = GAIN_W'(G2);
      3'd3:    g = GAIN_W'(G3);
      default: g = GAIN_W'(G4);
    endcase
    return g;
  endfunction

  // ---------------- S1: channel select and difference ----------------
  logic [IN_W-1:0]      mean_sel;
  logic [2:0]           scale_sel;
  logic                 ch_ok;
  logic signed [IN_W:0] diff_d;

  always_comb begin
    mean_sel  = '0;
    scale_sel = '0;
    ch_ok     = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (IN_CH == CH_W'(k)) begin
        mean_sel  = MEAN[k*IN_W +: IN_W];
        scale_sel = SCALE[k*3 +: 3];
        ch_ok     = 1'b1;
      end
    end
  end

  assign diff_d = $signed({1'b0, DATA_IN}) - $signed({1'b0, mean_sel});

  logic                 v1_q;
  logic [CH_W-1:0]      ch1_q;
  logic signed [IN_W:0] diff1_q;
  logic [IN_W-1:0]      mean1_q;
  logic [GAIN_W-1:0]    gain1_q;

  always_ff @(posedge CLK or posedge rst_sync) begin
    if (rst_sync) begin
      v1_q    <= 1'b0;
      ch1_q   <= '0;
      diff1_q <= '0;
      mean1_q <= '0;
      gain1_q <= '0;
    end else begin
      v1_q <= IN_VALID && ch_ok;
      if (IN_VALID && ch_ok) begin
        ch1_q   <= IN_CH;
        diff1_q <= diff_d;
        mean1_q <= mean_sel;
        gain1_q <= gain_of(scale_sel);
      end
    end
  end

  // ---------------- S2: products at full accumulator width ----------------
  logic signed [ACC_W-1:0] prod_d;
  logic signed [ACC_W-1:0] base_d;

  assign prod_d = ACC_W'(diff1_q) * ACC_W'($signed({1'b0, gain1_q}));
  assign base_d = ACC_W'($signed({1'b0, mean1_q})) * BASE_X;

  logic                    v2_q;
  logic [CH_W-1:0]         ch2_q;
  logic signed [ACC_W-1:0] prod2_q;
  logic signed [ACC_W-1:0] base2_q;

  always_ff @(posedge CLK or posedge rst_sync) begin
    if (rst_sync) begin
      v2_q    <= 1'b0;
      ch2_q   <= '0;
      prod2_q <= '0;
      base2_q <= '0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        ch2_q   <= ch1_q;
        prod2_q <= prod_d;
        base2_q <= base_d;
      end
    end
  end

  // ---------------- S3: accumulate (with optional rounding) ----------------
  logic                    v3_q;
  logic [CH_W-1:0]         ch3_q;
  logic signed [ACC_W-1:0] acc3_q;

  always_ff @(posedge CLK or posedge rst_sync) begin
    if (rst_sync) begin
      v3_q   <= 1'b0;
      ch3_q  <= '0;
      acc3_q <= '0;
    end else begin
      v3_q <= v2_q;
      if (v2_q) begin
        ch3_q  <= ch2_q;
        acc3_q <= base2_q + prod2_q + RND;
      end
    end
  end

  // ---------------- Shift and saturate into the output register ----------------
  logic signed [ACC_W-1:0] shifted;
  logic signed [63:0]      shifted_wide;
  logic [OUT_W-1:0]        res_data;
  logic                    res_sat;

  assign shifted      = acc3_q >>> FRAC_W;
  assign shifted_wide = 64'(shifted);

  always_comb begin
    res_data = OUT_W'(shifted);
    res_sat  = 1'b0;
    if (shifted[ACC_W-1]) begin
      res_data = '0;
      res_sat  = 1'b1;
    end else if (shifted_wide > MAX_OUT) begin
      res_data = '1;
      res_sat  = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge rst_sync) begin
    if (rst_sync) begin
      OUT_VALID <= 1'b0;
      OUT_CH    <= '0;
      DATA_OUT  <= '0;
      SAT       <= 1'b0;
      LAST_OUT  <= '0;
    end else begin
      OUT_VALID <= v3_q;
      if (v3_q) begin
        OUT_CH   <= ch3_q;
        DATA_OUT <= res_data;
        SAT      <= res_sat;
        for (int k = 0; k < N_CH; k++) begin
          if (ch3_q == CH_W'(k)) begin
            LAST_OUT[k*OUT_W +: OUT_W] <= res_data;
          end
        end
      end
    end
  end

endmodule
